// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory bus arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: MEM-first winner select with a starvation counter that
// forces an IF win after MAX_CONSEC back-to-back MEM grants while IF waits.
module dmem_arb_prio #(
    parameter int MAX_CONSEC = 4
) (
    input  logic clk,
    input  logic rstd,
    input  logic if_req,
    input  logic mem_req,
    input  logic grant_en,
    output logic mem_win,
    output logic if_win
);
    localparam int SW = $clog2(MAX_CONSEC + 1);
    logic [SW-1:0] r_starve_cnt;
    logic          w_starved;
    assign w_starved = if_req && (r_starve_cnt == SW'(MAX_CONSEC));
    assign mem_win   = mem_req && !w_starved;
    assign if_win    = if_req && !mem_win;
    // A MEM win with IF waiting implies the counter is below MAX_CONSEC, so it saturates there.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_starve_cnt <= '0;
        end else if (grant_en && mem_win) begin
            r_starve_cnt <= if_req ? r_starve_cnt + SW'(1) : '0;
        end else if (grant_en && if_win) begin
            r_starve_cnt <= '0;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency single-ported memory bus between
// instruction fetch and the MEM stage, one transaction outstanding at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_width,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_width,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(LAT + 1);
    state_t        r_state, w_state_nxt;
    owner_t        r_owner;
    logic [CW-1:0] r_cnt;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr, r_bus_wdata;
    logic [1:0]    r_bus_width;
    logic          w_grant_en, w_mem_win, w_if_win, w_done;

    assign w_grant_en = (r_state == IDLE);
    dmem_arb_prio #(.MAX_CONSEC(MAX_CONSEC)) u_prio (
        .clk      (clk),
        .rstd     (rstd),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .grant_en (w_grant_en),
        .mem_win  (w_mem_win),
        .if_win   (w_if_win)
    );
    assign mem_gnt    = w_grant_en && w_mem_win && !rstd;
    assign if_gnt     = w_grant_en && w_if_win && !rstd;
    assign w_done     = (r_state == WAIT) && (r_cnt == '0);
    assign mem_rvalid = w_done && (r_owner == OWN_MEM);
    assign if_rvalid  = w_done && (r_owner == OWN_IF);
    assign mem_rdata  = mem_rvalid ? bus_rdata : '0;
    assign if_rdata   = if_rvalid ? bus_rdata : '0;
    assign bus_en     = (r_state == ISSUE);
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_width  = r_bus_width;

    always_comb begin
        w_state_nxt = (r_state == IDLE)  ? ((mem_gnt || if_gnt) ? ISSUE : IDLE) :
                      (r_state == ISSUE) ? WAIT :
                      w_done             ? IDLE : WAIT;
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus qualifiers are captured at grant and held until the next grant.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_owner     <= OWN_IF;
            r_cnt       <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_width <= '0;
        end else begin
            if (r_state == ISSUE) begin
                r_cnt <= CW'(LAT - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (mem_gnt) begin
                r_owner     <= OWN_MEM;
                r_bus_we    <= mem_we;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
                r_bus_width <= mem_width;
            end else if (if_gnt) begin
                r_owner     <= OWN_IF;
                r_bus_we    <= 1'b0;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= '0;
                r_bus_width <= WIDTH_WORD;
            end
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported, fixed-latency memory bus between two requesters: the instruction-fetch unit (IF) and the memory-access stage (MEM).
- Sits between both pipeline units and the memory controller, with one transaction outstanding at a time.
- MEM has priority. A fairness counter bounds IF starvation.
- Every transaction, read or write, ends with a one-cycle rvalid to its owner.

Parameters:
- LAT, 2, bus read latency in cycles from the bus_en cycle to bus_rdata valid; must be >= 1.
- MAX_CONSEC, 4, maximum consecutive MEM grants while IF is waiting; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rstd  in  1  reset; asynchronous, active-high.
- if_req  in  1  IF request; held stable with if_addr until if_gnt.
- if_addr  in  32  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF transaction complete; if_rdata valid.
- if_rdata  out  32  IF read data.
- mem_req  in  1  MEM request; held stable with its qualifiers until mem_gnt.
- mem_we  in  1  MEM write enable.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  MEM write data.
- mem_width  in  2  access width: 00 byte, 01 half, 10 word.
- mem_gnt  out  1  MEM request accepted this cycle.
- mem_rvalid  out  1  MEM transaction complete; mem_rdata valid (write ack when mem_we).
- mem_rdata  out  32  MEM read data.
- bus_en  out  1  one-cycle bus command strobe.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_width  out  2  bus access width.
- bus_rdata  in  32  bus read data, valid LAT cycles after the bus_en cycle.

Behaviour:
- FSM states are IDLE, ISSUE and WAIT. A down-counter of width $clog2(LAT+1) tracks latency; owner is a 1-bit register (IF or MEM).
- Reset (async, rstd=1):
  - state=IDLE, owner=IF, counter=0, starve_cnt=0.
  - All bus_* outputs and all gnt/rvalid outputs are 0.
  - Any in-flight transaction is dropped; no rvalid is produced for it.
- IDLE:
  - gnt is combinational in this cycle (cycle T).
  - Winner selection: if mem_req && !(if_req && starve_cnt==MAX_CONSEC), MEM wins; else if if_req, IF wins.
  - On a grant, bus_* registers load at the end of T and state goes to ISSUE. IF grants load bus_we=0, bus_width=10, bus_wdata=0.
- ISSUE (cycle T+1):
  - bus_en=1 for exactly one cycle; counter loaded with LAT-1; go to WAIT.
- WAIT:
  - When counter==0 (cycle T+1+LAT), assert owner's rvalid combinationally, with rdata = bus_rdata; go to IDLE.
  - Otherwise decrement the counter.
- bus_addr/bus_we/bus_wdata/bus_width hold their value from the grant until the next grant.
- rdata outputs are 0 whenever their rvalid is 0.
- No arbitration occurs outside IDLE. Requests arriving during ISSUE/WAIT wait, with no gnt.
- Throughput is one transaction per LAT+2 cycles. A new grant is possible in the cycle after rvalid.
- Fairness (starve_cnt, saturating at MAX_CONSEC):
  - MEM grant while if_req=1: increment.
  - MEM grant while if_req=0: clear.
  - IF grant: clear.
- Requesters may drop or change req in the cycle after gnt. Dropping req before gnt is legal; no grant is then given.
- Simultaneous reset and rvalid: reset wins and rvalid is forced to 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum for state {IDLE, ISSUE, WAIT};
  - typedef enum for owner {OWN_IF, OWN_MEM};
  - width constants WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10.
- One sub-module, dmem_arb_prio: combinational winner select plus the registered starve_cnt, with inputs if_req, mem_req, grant_en.

Test Plan (LAT=2, MAX_CONSEC=4):
- Reset: assert rstd for 2 cycles with if_req=mem_req=1 -> all gnt/rvalid/bus_en=0 during reset; first grant after release goes to MEM.
- IF read: if_req=1, if_addr=0x100 at cycle 0 -> if_gnt cycle 0; bus_en=1, bus_addr=0x100, bus_we=0 at cycle 1; bus_rdata=0xDEADBEEF at cycle 3 -> if_rvalid=1, if_rdata=0xDEADBEEF at cycle 3; next grant possible at cycle 4.
- Contention: if_req and mem_req both rise at cycle 0 -> mem_gnt cycle 0, mem_rvalid cycle 3, if_gnt cycle 4, if_rvalid cycle 7.
- Starvation: both reqs held high continuously -> MEM granted 4 times (cycles 0,4,8,12), IF granted at cycle 16, MEM again at cycle 20; starve_cnt=0 after the IF grant.
- MEM byte write: mem_we=1, mem_width=00, mem_addr=0x2003, mem_wdata=0xA5 -> bus_en cycle 1 with bus_we=1, bus_width=00, bus_addr=0x2003, bus_wdata=0xA5; mem_rvalid ack at cycle 3.
- Reset mid-WAIT: grant IF at cycle 0, assert rstd at cycle 2 -> no if_rvalid at cycle 3; a fresh mem_req after release is granted from IDLE with starve_cnt=0.
